// File: rtl/clk_mon_pkg.sv
// Shared definitions for the clock frequency monitors.
// Holds the monitor FSM state type, default window/tolerance/fault constants
// and the expected edge count per monitored clock for a 100 us gate at 96 MHz.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StGate = 2'd2,
    StEval = 2'd3
  } mon_state_e;

  localparam int unsigned DEF_GATE_CYCLES  = 9600;
  localparam int unsigned DEF_TOL          = 2;
  localparam int unsigned DEF_FAIL_LIMIT   = 3;
  localparam int unsigned DEF_STUCK_CYCLES = 64;

  localparam int unsigned EXP_12M = 1200;
  localparam int unsigned EXP_6M  = 600;
  localparam int unsigned EXP_1M5 = 150;
  localparam int unsigned EXP_1M  = 100;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Ports:
//   clk   in  sampling clock
//   rst   in  asynchronous active-high reset
//   din   in  asynchronous input, treated as data
//   pulse out one-clk pulse per rising edge of din, 3 clk after the edge is sampled
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  // [0],[1]: synchronizer stages; [2]: previous synchronized value
  logic [2:0] sync_q;
  logic       pulse_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], din};
      pulse_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/clk_freq_monitor.sv
// Frequency monitor for one divided clock, using clk as the timebase.
// Counts meas_clk rising edges over a GATE_CYCLES-long window, compares the
// count against EXP_EDGES +/- TOL and raises a sticky fault after FAIL_LIMIT
// consecutive out-of-tolerance windows.
// Optional feature macro: CLK_FREQ_MONITOR_STUCK_EN adds a no-edge watchdog
// (stuck) that also sets fault immediately.
// Ports:
//   clk       in   timebase clock (>= 4x meas_clk)
//   rst       in   asynchronous active-high reset
//   meas_clk  in   monitored clock, asynchronous
//   en        in   keep measuring back-to-back windows
//   fault_clr in   pulse: clears fault and the failing-window run
//   busy      out  FSM not idle
//   edge_cnt  out  edge count of the last completed window
//   cnt_valid out  one-cycle pulse when edge_cnt updates
//   freq_ok   out  last completed window within tolerance
//   fault     out  sticky failure flag
//   stuck     out  no-edge alarm (0 unless the optional feature is built)
module clk_freq_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned GATE_CYCLES  = DEF_GATE_CYCLES,
  parameter int unsigned EXP_EDGES    = EXP_12M,
  parameter int unsigned TOL          = DEF_TOL,
  parameter int unsigned FAIL_LIMIT   = DEF_FAIL_LIMIT
`ifdef CLK_FREQ_MONITOR_STUCK_EN
  ,
  parameter int unsigned STUCK_CYCLES = DEF_STUCK_CYCLES
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             meas_clk,
  input  logic             en,
  input  logic             fault_clr,
  output logic             busy,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             cnt_valid,
  output logic             freq_ok,
  output logic             fault,
  output logic             stuck
);

  localparam int unsigned      FailW    = $clog2(FAIL_LIMIT + 1);
  localparam logic [CNT_W-1:0] GateLast = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] AccMax   = '1;
  localparam logic [CNT_W:0]   ExpExt   = (CNT_W + 1)'(EXP_EDGES);
  localparam logic [CNT_W:0]   TolExt   = (CNT_W + 1)'(TOL);
  localparam logic [FailW-1:0] FailMax  = FailW'(FAIL_LIMIT);

  mon_state_e       state_q;
  logic [CNT_W-1:0] gate_cnt_q;
  logic [CNT_W-1:0] edge_acc_q;
  logic [CNT_W-1:0] edge_cnt_q;
  logic             cnt_valid_q;
  logic             freq_ok_q;
  logic             fault_q;
  logic [FailW-1:0] fail_run_q;

  logic             edge_pulse;
  logic [CNT_W:0]   acc_ext;
  logic [CNT_W:0]   diff;
  logic             in_tol;
  logic [FailW-1:0] run_upd;
  logic             eval_set;
  logic             stuck_set;

  sync_edge_det u_sync_edge_det (
    .clk   (clk),
    .rst   (rst),
    .din   (meas_clk),
    .pulse (edge_pulse)
  );

  assign busy = (state_q != StIdle);

  // Window verdict; one extra bit keeps the absolute difference from wrapping.
  always_comb begin
    acc_ext = {1'b0, edge_acc_q};
    diff    = (acc_ext >= ExpExt) ? (acc_ext - ExpExt) : (ExpExt - acc_ext);
    in_tol  = (diff <= TolExt);
    if (in_tol) begin
      run_upd = '0;
    end else if (fail_run_q == FailMax) begin
      run_upd = FailMax;
    end else begin
      run_upd = fail_run_q + 1'b1;
    end
    eval_set = (state_q == StEval) && (run_upd == FailMax);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      gate_cnt_q  <= '0;
      edge_acc_q  <= '0;
      edge_cnt_q  <= '0;
      cnt_valid_q <= 1'b0;
      freq_ok_q   <= 1'b0;
      fault_q     <= 1'b0;
      fail_run_q  <= '0;
    end else begin
      cnt_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (en) state_q <= StArm;
        end
        StArm: begin
          gate_cnt_q <= '0;
          edge_acc_q <= '0;
          state_q    <= en ? StGate : StIdle;
        end
        StGate: begin
          if (!en) begin
            // Abort: partial window discarded, last results kept.
            state_q <= StIdle;
          end else begin
            gate_cnt_q <= gate_cnt_q + 1'b1;
            if (edge_pulse && (edge_acc_q != AccMax)) edge_acc_q <= edge_acc_q + 1'b1;
            if (gate_cnt_q == GateLast) state_q <= StEval;
          end
        end
        StEval: begin
          edge_cnt_q  <= edge_acc_q;
          cnt_valid_q <= 1'b1;
          freq_ok_q   <= in_tol;
          fail_run_q  <= run_upd;
          state_q     <= en ? StArm : StIdle;
        end
      endcase

      // A fault being set wins over a coincident clear.
      if (fault_clr && !eval_set) fail_run_q <= '0;
      if (eval_set || stuck_set) begin
        fault_q <= 1'b1;
      end else if (fault_clr) begin
        fault_q <= 1'b0;
      end
    end
  end

`ifdef CLK_FREQ_MONITOR_STUCK_EN
  localparam int unsigned       StuckW   = $clog2(STUCK_CYCLES + 1);
  localparam logic [StuckW-1:0] StuckMax = StuckW'(STUCK_CYCLES);

  logic [StuckW-1:0] stuck_cnt_q;
  logic              stuck_q;

  assign stuck_set = busy && !edge_pulse && !stuck_q && (stuck_cnt_q == StuckMax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stuck_cnt_q <= '0;
      stuck_q     <= 1'b0;
    end else begin
      if (!busy || edge_pulse) begin
        stuck_cnt_q <= '0;
      end else if (stuck_cnt_q != StuckMax) begin
        stuck_cnt_q <= stuck_cnt_q + 1'b1;
      end
      if (edge_pulse) begin
        stuck_q <= 1'b0;
      end else if (stuck_set) begin
        stuck_q <= 1'b1;
      end else if (fault_clr) begin
        stuck_q <= 1'b0;
      end
    end
  end

  assign stuck = stuck_q;
`else
  assign stuck_set = 1'b0;
  assign stuck     = 1'b0;
`endif

  assign edge_cnt  = edge_cnt_q;
  assign cnt_valid = cnt_valid_q;
  assign freq_ok   = freq_ok_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Self-checking bench for clk_freq_monitor (scaled window: 960 cycles, 120 edges).
// meas_clk follows a per-cycle level plan; the reference model counts plan
// rising edges that land inside each window, given the 3-cycle input latency.
module tb_clk_freq_monitor;

  localparam int unsigned CNT_W = 16;
  localparam int G    = 960;
  localparam int EXP  = 120;
  localparam int TOL  = 2;
  localparam int FL   = 3;
  localparam int MAXC = 32768;

  logic             clk = 1'b0;
  logic             rst;
  logic             meas_clk;
  logic             en;
  logic             fault_clr;
  logic             busy;
  logic [CNT_W-1:0] edge_cnt;
  logic             cnt_valid;
  logic             freq_ok;
  logic             fault;
  logic             stuck;

  clk_freq_monitor #(
    .CNT_W       (CNT_W),
    .GATE_CYCLES (G),
    .EXP_EDGES   (EXP),
    .TOL         (TOL),
    .FAIL_LIMIT  (FL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .meas_clk  (meas_clk),
    .en        (en),
    .fault_clr (fault_clr),
    .busy      (busy),
    .edge_cnt  (edge_cnt),
    .cnt_valid (cnt_valid),
    .freq_ok   (freq_ok),
    .fault     (fault),
    .stuck     (stuck)
  );

  always #5 clk = ~clk;

  // cyc == k between posedge k and posedge k+1
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit level [MAXC];
  int targets[$];

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  int m_run   = 0;
  bit m_fault = 1'b0;
  int m_cnt   = 0;
  bit m_ok    = 1'b0;

  // Level seen by the DUT at posedge k is level[k].
  initial begin
    meas_clk = 1'b0;
    forever begin
      @(negedge clk);
      meas_clk = (cyc + 1 < MAXC) ? level[cyc + 1] : 1'b0;
    end
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic plan_clear(input int from);
    for (int k = from; k < MAXC; k++) level[k] = 1'b0;
  endtask

  task automatic plan_periodic(input int from, input int period);
    int ph;
    ph = $urandom_range(0, period - 1);
    for (int k = from; k < MAXC; k++) level[k] = (((k - from + ph) % period) < 3);
  endtask

  // Exactly n rising edges, jittered, inside the counted range starting at 'start'.
  task automatic plan_count(input int start, input int n);
    int r;
    int pos;
    r = $urandom_range(0, n - 1);
    for (int k = start; k < start + G; k++) level[k] = 1'b0;
    for (int i = 0; i < n; i++) begin
      pos = start + 1 + (i * (G - 4) + r) / n;
      for (int d = 0; d < 3; d++) level[pos + d] = 1'b1;
    end
  endtask

  // Window whose ARM is taken at posedge e counts edge pulses consumed at
  // posedges e+2 .. e+1+G, i.e. meas_clk rises first seen at posedges e-1 .. e+G-2.
  function automatic int model_count(input int e);
    int n;
    n = 0;
    for (int k = e - 1; k <= e + G - 2; k++) if (level[k] && !level[k - 1]) n++;
    if (n > 65535) n = 65535;
    return n;
  endfunction

  task automatic model_eval(input int cnt, input bit clr);
    m_cnt = cnt;
    m_ok  = (cnt >= EXP - TOL) && (cnt <= EXP + TOL);
    if (m_ok) m_run = 0;
    else if (m_run < FL) m_run++;
    if (!m_ok && m_run == FL) begin
      m_fault = 1'b1;
    end else if (clr) begin
      m_fault = 1'b0;
      m_run   = 0;
    end
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    m_fault   = 1'b0;
    m_run     = 0;
    step();
    check_eq("fault_clr", fault, 0);
  endtask

  // Runs nwin back-to-back windows; window clr_win gets fault_clr on its EVAL.
  task automatic run_windows(input int nwin, input int clr_win);
    int c;
    int e0;
    int e;
    int got;
    c  = cyc;
    e0 = c + 3;
    for (int j = 0; j < targets.size() && j < nwin; j++) begin
      plan_count(e0 + j * (G + 2) - 1, targets[j]);
    end
    step();
    step();
    en = 1'b1;
    step();
    check_eq("busy_run", busy, 1);
    for (int j = 0; j < nwin; j++) begin
      bit clr;
      e   = e0 + j * (G + 2);
      clr = (j == clr_win);
      if (clr) begin
        while (cyc < e + 1 + G) step();
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
      end
      for (int n = 0; n < G + 8 && !cnt_valid; n++) step();
      got = cnt_valid ? cyc : -1;
      check_eq("valid_cyc", got, e + 2 + G);
      model_eval(model_count(e), clr);
      check_eq("edge_cnt", edge_cnt, m_cnt);
      check_eq("freq_ok", freq_ok, m_ok);
      check_eq("fault", fault, m_fault);
      step();
      check_eq("valid_pulse", cnt_valid, 0);
    end
    en = 1'b0;
    step();
    step();
    step();
    check_eq("busy_idle", busy, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int seen;
    int got;
    rst       = 1'b1;
    en        = 1'b0;
    fault_clr = 1'b0;
    repeat (3) step();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_edge_cnt", edge_cnt, 0);
    check_eq("rst_cnt_valid", cnt_valid, 0);
    check_eq("rst_freq_ok", freq_ok, 0);
    check_eq("rst_fault", fault, 0);
    check_eq("rst_stuck", stuck, 0);
    rst = 1'b0;
    repeat (3) step();

    // Nominal clock, period 8
    plan_periodic(cyc + 2, 8);
    run_windows(2, -1);

    // Slow clock, period 9: fault after the third failing window
    plan_periodic(cyc + 2, 9);
    run_windows(3, -1);
    pulse_clr();

    // Run restarted from zero; clear coinciding with the setting EVAL loses
    plan_periodic(cyc + 2, 9);
    run_windows(3, 2);
    pulse_clr();

    // Tolerance boundaries plus random counts
    plan_clear(cyc + 2);
    targets.delete();
    targets.push_back(EXP - 2);
    targets.push_back(EXP + 2);
    targets.push_back(EXP + 3);
    targets.push_back($urandom_range(EXP - 6, EXP + 6));
    targets.push_back($urandom_range(EXP - 6, EXP + 6));
    run_windows(5, -1);
    targets.delete();
    pulse_clr();

    // Abort mid-window, then a full new window
    plan_periodic(cyc + 2, 8);
    step();
    step();
    e0 = cyc + 1;
    en = 1'b1;
    while (cyc < e0 + 1 + G / 2) step();
    en = 1'b0;
    step();
    step();
    check_eq("busy_abort", busy, 0);
    seen = 0;
    for (int n = 0; n < G + 10; n++) begin
      if (cnt_valid) seen++;
      step();
    end
    check_eq("abort_no_valid", seen, 0);
    check_eq("abort_edge_cnt", edge_cnt, m_cnt);
    check_eq("abort_freq_ok", freq_ok, m_ok);
    run_windows(1, -1);

    // meas_clk held low, then reset mid-window
    plan_clear(cyc + 2);
    repeat (8) step();
    e0 = cyc + 1;
    en = 1'b1;
`ifdef CLK_FREQ_MONITOR_STUCK_EN
    got = -1;
    for (int n = 0; n < 100 && !stuck; n++) step();
    if (stuck) got = cyc;
    check_eq("stuck_cyc", got, e0 + 65);
    check_eq("stuck_fault", fault, 1);
`else
    got = 0;
    for (int n = 0; n < 100; n++) begin
      if (stuck) got++;
      step();
    end
    check_eq("stuck_off", got, 0);
    check_eq("stuck_off_fault", fault, m_fault);
`endif
    while (cyc < e0 + 300) step();
    check_eq("busy_mid", busy, 1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_edge_cnt", edge_cnt, 0);
    check_eq("mid_rst_cnt_valid", cnt_valid, 0);
    check_eq("mid_rst_freq_ok", freq_ok, 0);
    check_eq("mid_rst_fault", fault, 0);
    check_eq("mid_rst_stuck", stuck, 0);
    step();
    rst     = 1'b0;
    en      = 1'b0;
    m_run   = 0;
    m_fault = 1'b0;
    m_cnt   = 0;
    m_ok    = 1'b0;
    repeat (3) step();
    check_eq("busy_after_rst", busy, 0);

    // Recovery after reset
    plan_periodic(cyc + 2, 8);
    run_windows(1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/clk_freq_monitor.md
Name: clk_freq_monitor

Overview:
- Measures the frequency of one divided clock produced by the clock-generation block, using the fast system clock as the timebase.
- Flags any clock whose edge count in a fixed gate window falls outside tolerance.
- Instantiated once per monitored clock (12M, 6M, 1M5, 1M) beside the NAND controller.
- Its fault output gates controller start-up and raises a health alarm.

Parameters:
- CNT_W, 16, width of the edge counter and of edge_cnt.
- GATE_CYCLES, 9600, clk cycles per gate window (100 us at 96 MHz); legal range 2 .. 2^CNT_W-1.
- EXP_EDGES, 1200, expected meas_clk rising edges per window.
- TOL, 2, allowed absolute deviation in edges, inclusive.
- FAIL_LIMIT, 3, consecutive out-of-tolerance windows before fault asserts; minimum 1.
- STUCK_CYCLES, 64, clk cycles without a meas_clk edge before the stuck flag asserts (optional feature only).

Ports:
- clk  in  1  timebase clock; must be at least 4x meas_clk frequency.
- rst  in  1  reset, asynchronous, active-high.
- meas_clk  in  1  monitored clock; asynchronous to clk and treated as data only.
- en  in  1  level; 1 = keep measuring back-to-back windows.
- fault_clr  in  1  single-cycle pulse; clears fault and fail_run.
- busy  out  1  1 while in ARM, GATE or EVAL.
- edge_cnt  out  CNT_W  edge count of the last completed window.
- cnt_valid  out  1  one-cycle pulse when edge_cnt updates.
- freq_ok  out  1  result of the last completed window.
- fault  out  1  sticky failure flag.
- stuck  out  1  no-edge alarm; tied 0 unless the optional feature is compiled in.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; gate counter, edge counter and fail_run counter at 0.
- Input sampling: meas_clk passes through a 2-FF synchronizer, then a rising-edge detector that produces a one-clk pulse per rising edge.
- Fixed input latency is 3 clk cycles. It is identical at window start and end, so it does not bias the count.
- FSM IDLE: stays while en=0. en=1 moves to ARM.
- FSM ARM (1 cycle): clears gate_cnt and edge_acc, then moves to GATE.
- FSM GATE: gate_cnt increments every cycle.
  - Each edge pulse increments edge_acc, saturating at 2^CNT_W-1.
  - An edge pulse on the cycle gate_cnt==GATE_CYCLES-1 is counted.
  - At gate_cnt==GATE_CYCLES-1 the FSM moves to EVAL, so the window is exactly GATE_CYCLES cycles.
- FSM EVAL (1 cycle):
  - edge_cnt <= edge_acc and cnt_valid=1.
  - freq_ok <= (|edge_acc - EXP_EDGES| <= TOL), computed as an unsigned compare on CNT_W+1 bits with no wrap.
  - If freq_ok is 0, fail_run increments, saturating at FAIL_LIMIT; otherwise fail_run clears.
  - fault is set when the updated fail_run reaches FAIL_LIMIT.
  - Next state is ARM if en=1, else IDLE. Back-to-back windows therefore have a 2-cycle dead time (EVAL + ARM).
- en deasserted during ARM or GATE: abort to IDLE on the next cycle. No cnt_valid; edge_cnt, freq_ok and fail_run keep their values.
- fault_clr: clears fault and fail_run. If it coincides with an EVAL that sets fault, the set wins and fail_run holds FAIL_LIMIT.
- busy = (state != IDLE).
- rst asserted at any point returns everything to reset values immediately. A partial window is discarded.

Optional Feature:
- Macro CLK_FREQ_MONITOR_STUCK_EN.
- When defined:
  - A counter counts clk cycles since the last edge pulse, while busy=1.
  - stuck asserts when the counter reaches STUCK_CYCLES and stays set until the next edge pulse, fault_clr, or rst.
  - The counter clears on an edge pulse and when not busy.
  - stuck asserting also sets fault immediately, without waiting for the window to end.
- When undefined: no counter is built, stuck is constant 0, and fault comes only from the window compare.

Decomposition:
- Shared package clk_mon_pkg holds:
  - the FSM state typedef (IDLE, ARM, GATE, EVAL, 2 bits);
  - default constants for GATE_CYCLES, TOL and FAIL_LIMIT;
  - per-clock EXP_EDGES constants: EXP_12M=1200, EXP_6M=600, EXP_1M5=150, EXP_1M=100.
- Sub-module sync_edge_det (2-FF synchronizer plus rising-edge pulse) is natural and reusable for the other asynchronous inputs.

Test Plan:
- meas_clk period 8 clk, en=1 -> cnt_valid every 9602 cycles, edge_cnt=1200, freq_ok=1, fault=0.
- meas_clk period 9 clk -> edge_cnt=1066 or 1067, freq_ok=0; fault rises in the 3rd EVAL, and fault_clr then drops fault and zeroes fail_run.
- Tolerance boundary, with jitter forcing 1198, 1202 and 1203 edges -> freq_ok=1, 1, 0 respectively.
- en dropped at gate cycle 5000 -> no cnt_valid, busy=0 two cycles later, edge_cnt unchanged; en reasserted -> a full new window.
- fault_clr in the same cycle as the 3rd failing EVAL -> fault=1 afterwards.
- meas_clk held 0 with the macro defined -> stuck=1 and fault=1 at cycle 64 after GATE entry. Then rst mid-window -> all outputs 0 and state IDLE.
